// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flop process one
// bit per clock, LSB first, and the registered result is published with a done pulse.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_op_sub,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [WIDTH-1:0] r_opA;
    logic [WIDTH-1:0] r_opB;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic             w_sBit;
    logic             w_cNext;
    logic             w_lastBit;
    logic             w_capture;
    logic             w_step;
    logic             w_busy;
    logic             w_done;
    logic [WIDTH-1:0] w_opANext;

    assign w_sBit    = r_opA[0] ^ r_opB[0] ^ r_carry;
    assign w_cNext   = (r_opA[0] & r_opB[0]) | (r_opA[0] & r_carry) | (r_opB[0] & r_carry);
    assign w_lastBit = (r_cnt == LAST_BIT);

    // Sum bits refill the vacated MSB of the A register, so after WIDTH shifts it holds the result.
    generate
        if (WIDTH == 1) begin : g_single
            assign w_opANext = w_sBit;
        end else begin : g_multi
            assign w_opANext = {w_sBit, r_opA[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_capture   = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_capture   = 1'b1;
                    w_nextState = S_RUN;
                end
            end
            S_RUN: begin
                w_busy = 1'b1;
                w_step = 1'b1;
                if (w_lastBit) begin
                    w_nextState = S_DONE;
                end
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opA   <= '0;
            r_opB   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (w_capture) begin
            r_opA   <= i_a;
            r_opB   <= i_b ^ {WIDTH{i_op_sub}};
            r_carry <= i_op_sub | i_cin;
            r_cnt   <= '0;
        end else if (w_step) begin
            r_opA   <= w_opANext;
            r_opB   <= r_opB >> 1;
            r_carry <= w_cNext;
            r_cnt   <= r_cnt + CW'(1);
        end
    end

    // On the last bit r_carry is the carry into the MSB, giving signed overflow directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_step && w_lastBit) begin
            r_sum  <= w_opANext;
            r_cout <= w_cNext;
            r_ovf  <= r_carry ^ w_cNext;
        end
    end

    assign o_busy = w_busy;
    assign o_done = w_done;
    assign o_sum  = r_sum;
    assign o_cout = r_cout;
    assign o_ovf  = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed vector table, multi-cycle corner
// sequences and randomised operations against an arithmetic reference model.
module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start8, opSub8, cin8, busy8, done8, cout8, ovf8;
    logic [7:0] a8, b8, sum8;
    logic       start1, opSub1, cin1, busy1, done1, cout1, ovf1;
    logic [0:0] a1, b1, sum1;

    int vectors     = 0;
    int miscompares = 0;
    logic [7:0] lastSum8 = 8'h00;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .i_start(start8), .i_op_sub(opSub8),
        .i_a(a8), .i_b(b8), .i_cin(cin8), .o_busy(busy8), .o_done(done8),
        .o_sum(sum8), .o_cout(cout8), .o_ovf(ovf8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .i_start(start1), .i_op_sub(opSub1),
        .i_a(a1), .i_b(b1), .i_cin(cin1), .o_busy(busy1), .o_done(done1),
        .o_sum(sum1), .o_cout(cout1), .o_ovf(ovf1)
    );

    typedef struct {
        logic       opSub;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] expSum;
        logic       expCout;
        logic       expOvf;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference: signed/unsigned integer arithmetic, returns {ovf, cout, sum}
    function automatic logic [9:0] refModel(input logic opSub, input logic [7:0] a, input logic [7:0] b,
                                            input logic cin);
        int ua, ub, us, sa, sb, ss;
        logic cout, ovf;
        ua = a;
        ub = b;
        sa = $signed(a);
        sb = $signed(b);
        if (opSub) begin
            us   = ua - ub;
            ss   = sa - sb;
            cout = (ua >= ub);
        end else begin
            us   = ua + ub + int'(cin);
            ss   = sa + sb + int'(cin);
            cout = (us > 255);
        end
        ovf = (ss > 127) || (ss < -128);
        return {ovf, cout, us[7:0]};
    endfunction

    task automatic applyStimulus(input string name, input logic opSub, input logic [7:0] a, input logic [7:0] b,
                                 input logic cin, input logic [7:0] expSum, input logic expCout,
                                 input logic expOvf, input logic interfere);
        a8     = a;
        b8     = b;
        cin8   = cin;
        opSub8 = opSub;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        checkOutput($sformatf("%s busy after start", name), {31'd0, busy8}, 32'd1);
        for (int k = 1; k <= 8; k++) begin
            if (interfere && k <= 6) begin
                start8 = k[0];
                a8     = 8'($urandom);
                b8     = 8'($urandom);
                opSub8 = 1'($urandom);
                cin8   = 1'($urandom);
            end else begin
                start8 = 1'b0;
                a8     = 8'($urandom);
                b8     = 8'($urandom);
            end
            tick();
            if (k < 8) begin
                checkOutput($sformatf("%s run k=%0d {done,busy,sum}", name, k),
                            {22'd0, done8, busy8, sum8}, {22'd0, 1'b0, 1'b1, lastSum8});
            end else begin
                checkOutput($sformatf("%s done/busy", name), {30'd0, done8, busy8}, {30'd0, 1'b1, 1'b0});
                checkOutput($sformatf("%s result {ovf,cout,sum}", name),
                            {22'd0, ovf8, cout8, sum8}, {22'd0, expOvf, expCout, expSum});
            end
        end
        lastSum8 = expSum;
        tick();
        checkOutput($sformatf("%s after done {done,busy}", name), {30'd0, done8, busy8}, 32'd0);
    endtask

    task automatic runOp1(input string name, input logic a, input logic b, input logic expSum,
                          input logic expCout);
        a1     = a;
        b1     = b;
        cin1   = 1'b0;
        opSub1 = 1'b0;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        checkOutput($sformatf("%s busy", name), {31'd0, busy1}, 32'd1);
        tick();
        checkOutput($sformatf("%s {done,busy,ovf,cout,sum}", name),
                    {27'd0, done1, busy1, ovf1, cout1, sum1}, {27'd0, 1'b1, 1'b0, expCout, expCout, expSum});
        tick();
        checkOutput($sformatf("%s done cleared", name), {31'd0, done1}, 32'd0);
    endtask

    initial begin
        logic [9:0] model;
        int         doneCount;

        vecs[0] = '{1'b0, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
        vecs[1] = '{1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 8'h10, 8'h20, 1'b0, 8'hF0, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 8'h10, 8'h10, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1};

        rst_n  = 1'b0;
        start8 = 1'b0; opSub8 = 1'b0; cin8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        start1 = 1'b0; opSub1 = 1'b0; cin1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
        #1;
        checkOutput("reset state w8", {21'd0, busy8, done8, cout8, ovf8, sum8}, 32'd0);
        checkOutput("reset state w1", {27'd0, busy1, done1, cout1, ovf1, sum1}, 32'd0);
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i].opSub, vecs[i].a, vecs[i].b, vecs[i].cin,
                          vecs[i].expSum, vecs[i].expCout, vecs[i].expOvf, 1'b0);
        end

        // Reset in the middle of an operation: previous result 0x7F must be wiped
        a8 = 8'h33; b8 = 8'h44; opSub8 = 1'b0; cin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        checkOutput("midrun reset outputs", {21'd0, busy8, done8, cout8, ovf8, sum8}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        lastSum8  = 8'h00;
        doneCount = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (done8 || busy8) doneCount++;
        end
        checkOutput("no activity after reset release", doneCount, 0);
        applyStimulus("post-reset 7+1", 1'b0, 8'h07, 8'h01, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0);

        applyStimulus("interference", 1'b0, 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("no queued op after interference", {30'd0, busy8, done8}, 32'd0);

        for (int i = 0; i < 30; i++) begin
            logic       rs, rc;
            logic [7:0] ra, rb;
            rs    = 1'($urandom);
            rc    = 1'($urandom);
            ra    = 8'($urandom);
            rb    = 8'($urandom);
            model = refModel(rs, ra, rb, rc);
            applyStimulus($sformatf("rand%0d", i), rs, ra, rb, rc, model[7:0], model[8], model[9], 1'b0);
        end

        runOp1("ha 00", 1'b0, 1'b0, 1'b0, 1'b0);
        runOp1("ha 01", 1'b0, 1'b1, 1'b1, 1'b0);
        runOp1("ha 10", 1'b1, 1'b0, 1'b1, 1'b0);
        runOp1("ha 11", 1'b1, 1'b1, 1'b0, 1'b1);

        // start held high: RUN, DONE, IDLE repeat, so done every third edge
        a1 = 1'b1; b1 = 1'b1; start1 = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            checkOutput($sformatf("b2b done k=%0d", k), {31'd0, done1}, {31'd0, (k % 3) == 2});
            if ((k % 3) == 2) begin
                checkOutput($sformatf("b2b result k=%0d", k), {30'd0, cout1, sum1}, 32'd2);
            end
        end
        start1 = 1'b0;
        tick(); tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
